// File: rtl/data_mem_port.sv
// ----------------------------------------------------------------------------
// data_mem_port
//
// Data-side memory port between execute_load and a req/gnt/rvalid data bus.
// Accepts one load request at a time, checks size/alignment/range, issues a
// word-aligned bus read and returns the addressed byte/half/word right-aligned
// and zero-extended. Misalignment, out-of-range, bus error and timeout are all
// reported as a one-cycle access-fault pulse.
//
// Parameters
//   MEM_BASE  first valid data address
//   MEM_SIZE  size of the valid range in bytes
//   TIMEOUT   max cycles spent waiting for a read return (>= 1)
//
// Ports
//   i_clk                    clock, all state on rising edge
//   i_rst_n                  asynchronous active-low reset
//   i_flush                  abandon the current request, no response
//   i_mem_data_addr          byte address of the load
//   i_mem_data_addr_valid    request valid, held stable until response
//   i_mem_data_size          0=byte 1=half 2=word 3=illegal
//   o_mem_data_in            extracted read data, zero-extended
//   o_mem_data_valid         one-cycle pulse, data good
//   o_mem_data_access_fault  one-cycle pulse, request failed
//   o_bus_addr               word-aligned bus address
//   o_bus_req                bus read request, held until i_bus_gnt
//   i_bus_gnt                bus accepted the request this cycle
//   i_bus_rdata              bus read word, valid with i_bus_rvalid
//   i_bus_rvalid             bus read data return
//   i_bus_err                bus error return (replaces rvalid)
// ----------------------------------------------------------------------------
module data_mem_port #(
    parameter logic [31:0] MEM_BASE = 32'h0000_0000,
    parameter logic [31:0] MEM_SIZE = 32'h0001_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_flush,
    input  logic [31:0] i_mem_data_addr,
    input  logic        i_mem_data_addr_valid,
    input  logic [1:0]  i_mem_data_size,
    output logic [31:0] o_mem_data_in,
    output logic        o_mem_data_valid,
    output logic        o_mem_data_access_fault,
    output logic [31:0] o_bus_addr,
    output logic        o_bus_req,
    input  logic        i_bus_gnt,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_rvalid,
    input  logic        i_bus_err
);

    // Counter only has to reach TIMEOUT-1.
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StResp,
        StDrain
    } state_e;

    state_e          r_state;
    logic [1:0]      r_addr_lo;
    logic [1:0]      r_size;
    logic [CntW-1:0] r_cnt;
    logic            r_drain_pend;
    logic [31:0]     r_data;
    logic            r_valid;
    logic            r_fault;
    logic            r_bus_req;
    logic [31:0]     r_bus_addr;

    state_e          w_state_next;
    logic [1:0]      w_addr_lo_next;
    logic [1:0]      w_size_next;
    logic [CntW-1:0] w_cnt_next;
    logic            w_drain_pend_next;
    logic [31:0]     w_data_next;
    logic            w_valid_next;
    logic            w_fault_next;
    logic            w_bus_req_next;
    logic [31:0]     w_bus_addr_next;

    logic [31:0]     w_offset;
    logic            w_in_range;
    logic            w_misaligned;
    logic            w_illegal;
    logic [31:0]     w_extract;
    logic            w_ret;

    // ------------------------------------------------------------------------
    // Request legality, evaluated on the live request in IDLE
    // ------------------------------------------------------------------------
    always_comb begin
        w_offset     = i_mem_data_addr - MEM_BASE;
        w_in_range   = (i_mem_data_addr >= MEM_BASE) && (w_offset < MEM_SIZE);
        w_misaligned = ((i_mem_data_size == 2'd1) && i_mem_data_addr[0]) ||
                       ((i_mem_data_size == 2'd2) && (i_mem_data_addr[1:0] != 2'b00));
        w_illegal    = (i_mem_data_size == 2'd3) || w_misaligned || !w_in_range;
    end

    // ------------------------------------------------------------------------
    // Lane extraction from the returned word using the latched request
    // ------------------------------------------------------------------------
    always_comb begin
        w_extract = 32'h0;
        unique case (r_size)
            2'd0: begin
                unique case (r_addr_lo)
                    2'd0: w_extract = {24'h0, i_bus_rdata[7:0]};
                    2'd1: w_extract = {24'h0, i_bus_rdata[15:8]};
                    2'd2: w_extract = {24'h0, i_bus_rdata[23:16]};
                    2'd3: w_extract = {24'h0, i_bus_rdata[31:24]};
                    default: w_extract = 32'h0;
                endcase
            end
            2'd1: w_extract = r_addr_lo[1] ? {16'h0, i_bus_rdata[31:16]}
                                           : {16'h0, i_bus_rdata[15:0]};
            default: w_extract = i_bus_rdata;
        endcase
    end

    assign w_ret = i_bus_rvalid || i_bus_err;

    // ------------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_addr_lo_next    = r_addr_lo;
        w_size_next       = r_size;
        w_cnt_next        = r_cnt;
        w_drain_pend_next = r_drain_pend;
        w_bus_addr_next   = r_bus_addr;
        // Pulses and data are zero unless this cycle transitions into RESP.
        w_data_next       = 32'h0;
        w_valid_next      = 1'b0;
        w_fault_next      = 1'b0;
        w_bus_req_next    = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i_mem_data_addr_valid && !i_flush) begin
                    w_addr_lo_next    = i_mem_data_addr[1:0];
                    w_size_next       = i_mem_data_size;
                    w_drain_pend_next = 1'b0;
                    if (w_illegal) begin
                        w_state_next = StResp;
                        w_fault_next = 1'b1;
                    end else begin
                        w_state_next    = StReq;
                        w_bus_req_next  = 1'b1;
                        w_bus_addr_next = {i_mem_data_addr[31:2], 2'b00};
                    end
                end
            end

            StReq: begin
                if (i_flush) begin
                    // A grant in the flush cycle still owes the bus a return.
                    w_state_next = i_bus_gnt ? StDrain : StIdle;
                end else if (i_bus_gnt) begin
                    w_state_next = StWait;
                    w_cnt_next   = '0;
                end else begin
                    w_bus_req_next = 1'b1;
                end
            end

            StWait: begin
                if (i_flush) begin
                    // A return arriving with the flush is consumed and dropped.
                    w_state_next = w_ret ? StIdle : StDrain;
                end else if (i_bus_rvalid) begin
                    w_state_next = StResp;
                    w_valid_next = 1'b1;
                    w_data_next  = w_extract;
                end else if (i_bus_err) begin
                    w_state_next = StResp;
                    w_fault_next = 1'b1;
                end else if (r_cnt == CntLast) begin
                    // Read is still outstanding; swallow its late return.
                    w_state_next      = StResp;
                    w_fault_next      = 1'b1;
                    w_drain_pend_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CntW'(1);
                end
            end

            StResp: begin
                w_state_next      = r_drain_pend ? StDrain : StIdle;
                w_drain_pend_next = 1'b0;
            end

            StDrain: begin
                if (w_ret) begin
                    w_state_next = StIdle;
                end
            end

            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_addr_lo    <= 2'b00;
            r_size       <= 2'b00;
            r_cnt        <= '0;
            r_drain_pend <= 1'b0;
            r_data       <= 32'h0;
            r_valid      <= 1'b0;
            r_fault      <= 1'b0;
            r_bus_req    <= 1'b0;
            r_bus_addr   <= 32'h0;
        end else begin
            r_state      <= w_state_next;
            r_addr_lo    <= w_addr_lo_next;
            r_size       <= w_size_next;
            r_cnt        <= w_cnt_next;
            r_drain_pend <= w_drain_pend_next;
            r_data       <= w_data_next;
            r_valid      <= w_valid_next;
            r_fault      <= w_fault_next;
            r_bus_req    <= w_bus_req_next;
            r_bus_addr   <= w_bus_addr_next;
        end
    end

    assign o_mem_data_in           = r_data;
    assign o_mem_data_valid        = r_valid;
    assign o_mem_data_access_fault = r_fault;
    assign o_bus_req               = r_bus_req;
    assign o_bus_addr              = r_bus_addr;

endmodule

// File: tb/tb_data_mem_port.sv
// ----------------------------------------------------------------------------
// tb_data_mem_port
//
// Self-checking bench for data_mem_port. The bench plays both execute_load and
// the data bus; expected results come from a transaction-level model of the
// load rules (legality and lane extraction by plain arithmetic) and from the
// cycle numbers at which the bench itself drives gnt/rvalid/err.
// ----------------------------------------------------------------------------
module tb_data_mem_port;

    localparam logic [31:0] MEM_BASE = 32'h0000_0000;
    localparam logic [31:0] MEM_SIZE = 32'h0001_0000;
    localparam int unsigned TIMEOUT  = 16;

    localparam int KindRvalid = 0;
    localparam int KindErr    = 1;
    localparam int KindNone   = 2;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] addr;
    logic        addr_valid;
    logic [1:0]  size;
    logic [31:0] data_in;
    logic        data_valid;
    logic        fault;
    logic [31:0] bus_addr;
    logic        bus_req;
    logic        bus_gnt;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
    logic        bus_err;

    int n_cmp;
    int n_bad;

    data_mem_port #(
        .MEM_BASE (MEM_BASE),
        .MEM_SIZE (MEM_SIZE),
        .TIMEOUT  (TIMEOUT)
    ) u_dut (
        .i_clk                   (clk),
        .i_rst_n                 (rst_n),
        .i_flush                 (flush),
        .i_mem_data_addr         (addr),
        .i_mem_data_addr_valid   (addr_valid),
        .i_mem_data_size         (size),
        .o_mem_data_in           (data_in),
        .o_mem_data_valid        (data_valid),
        .o_mem_data_access_fault (fault),
        .o_bus_addr              (bus_addr),
        .o_bus_req               (bus_req),
        .i_bus_gnt               (bus_gnt),
        .i_bus_rdata             (bus_rdata),
        .i_bus_rvalid            (bus_rvalid),
        .i_bus_err               (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, {31'h0, data_valid}, 32'h0);
        chk({tag, "_fault"}, {31'h0, fault}, 32'h0);
        chk({tag, "_data"}, data_in, 32'h0);
    endtask

    // Reference rules for a load request.
    function automatic bit model_legal(input logic [31:0] a, input logic [1:0] s);
        longint unsigned ua;
        ua = a;
        if (s == 2'd3) return 0;
        if (s == 2'd1 && (ua % 2) != 0) return 0;
        if (s == 2'd2 && (ua % 4) != 0) return 0;
        if (ua < MEM_BASE) return 0;
        if (ua - MEM_BASE >= MEM_SIZE) return 0;
        return 1;
    endfunction

    function automatic logic [31:0] model_extract(input logic [31:0] w, input logic [31:0] a,
                                                  input logic [1:0] s);
        longint unsigned ww;
        ww = w;
        if (s == 2'd0) return 32'((ww >> (8 * (a % 4))) % 256);
        if (s == 2'd1) return 32'((ww >> (16 * ((a / 2) % 2))) % 65536);
        return w;
    endfunction

    // One load: request at cycle 0, gnt at cycle 1+gdly, return at g+1+rdly.
    task automatic do_load(input logic [31:0] a, input logic [1:0] s, input int gdly,
                           input int rdly, input int kind, input logic [31:0] rd);
        bit          ok;
        logic [31:0] exp;
        ok  = model_legal(a, s);
        exp = model_extract(rd, a, s);
        addr       = a;
        size       = s;
        addr_valid = 1'b1;
        step();
        if (!ok) begin
            chk("ill_fault", {31'h0, fault}, 32'h1);
            chk("ill_valid", {31'h0, data_valid}, 32'h0);
            chk("ill_data", data_in, 32'h0);
            chk("ill_req", {31'h0, bus_req}, 32'h0);
            addr_valid = 1'b0;
            step();
            chk("ill_after_req", {31'h0, bus_req}, 32'h0);
            chk_quiet("ill_after");
            return;
        end
        chk("bus_addr", bus_addr, {a[31:2], 2'b00});
        for (int c = 0; c <= gdly; c++) begin
            chk("req_held", {31'h0, bus_req}, 32'h1);
            chk_quiet("req_phase");
            if (c == gdly) bus_gnt = 1'b1;
            step();
            bus_gnt = 1'b0;
        end
        if (kind == KindNone) begin
            for (int c = 0; c < int'(TIMEOUT); c++) begin
                chk("wait_req", {31'h0, bus_req}, 32'h0);
                chk_quiet("wait_phase");
                step();
            end
            chk("to_fault", {31'h0, fault}, 32'h1);
            chk("to_valid", {31'h0, data_valid}, 32'h0);
            chk("to_data", data_in, 32'h0);
            // Request kept up through DRAIN must not be taken.
            step();
            for (int c = 0; c < 5; c++) begin
                chk("drain_req", {31'h0, bus_req}, 32'h0);
                chk_quiet("drain");
                step();
            end
            bus_rvalid = 1'b1;
            bus_rdata  = 32'h1234_5678;
            addr_valid = 1'b0;
            step();
            bus_rvalid = 1'b0;
            chk("post_drain_req", {31'h0, bus_req}, 32'h0);
            chk_quiet("post_drain");
            step();
            chk("post_drain_req2", {31'h0, bus_req}, 32'h0);
            return;
        end
        for (int c = 0; c <= rdly; c++) begin
            chk("wait_req", {31'h0, bus_req}, 32'h0);
            chk_quiet("wait_phase");
            if (c == rdly) begin
                bus_rdata  = rd;
                bus_rvalid = (kind == KindRvalid);
                bus_err    = (kind == KindErr);
            end
            step();
            bus_rvalid = 1'b0;
            bus_err    = 1'b0;
            bus_rdata  = $urandom;
        end
        if (kind == KindRvalid) begin
            chk("rsp_valid", {31'h0, data_valid}, 32'h1);
            chk("rsp_fault", {31'h0, fault}, 32'h0);
            chk("rsp_data", data_in, exp);
        end else begin
            chk("err_fault", {31'h0, fault}, 32'h1);
            chk("err_valid", {31'h0, data_valid}, 32'h0);
            chk("err_data", data_in, 32'h0);
        end
        addr_valid = 1'b0;
        step();
        chk_quiet("after_rsp");
    endtask

    initial begin
        logic [31:0] ra;
        logic [1:0]  rs;
        int          kind;

        n_cmp      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        addr       = 32'h0;
        addr_valid = 1'b0;
        size       = 2'd0;
        bus_gnt    = 1'b0;
        bus_rdata  = 32'h0;
        bus_rvalid = 1'b0;
        bus_err    = 1'b0;

        #7;
        chk("rst_req", {31'h0, bus_req}, 32'h0);
        chk("rst_addr", bus_addr, 32'h0);
        chk_quiet("rst");
        #5 rst_n = 1'b1;
        step();

        // Directed loads
        do_load(32'h0000_0100, 2'd2, 0, 0, KindRvalid, 32'hDEAD_BEEF);
        do_load(32'h0000_0103, 2'd0, 0, 0, KindRvalid, 32'h8877_6655);
        do_load(32'h0000_0102, 2'd1, 1, 2, KindRvalid, 32'h8877_6655);
        do_load(32'h0000_0101, 2'd1, 0, 0, KindRvalid, 32'h0);
        do_load(32'h0000_0102, 2'd2, 0, 0, KindRvalid, 32'h0);
        do_load(32'h0000_0100, 2'd3, 0, 0, KindRvalid, 32'h0);
        do_load(MEM_BASE + MEM_SIZE, 2'd0, 0, 0, KindRvalid, 32'h0);
        do_load(MEM_BASE + MEM_SIZE - 1, 2'd0, 0, 0, KindRvalid, 32'hA1B2_C3D4);
        do_load(32'h0000_0200, 2'd2, 3, 1, KindErr, 32'h0);
        do_load(32'h0000_0204, 2'd2, 0, int'(TIMEOUT) - 1, KindRvalid, 32'h0BAD_F00D);
        do_load(32'h0000_0208, 2'd2, 2, 0, KindNone, 32'h0);

        // Flush in REQ without gnt
        addr = 32'h0000_0300; size = 2'd2; addr_valid = 1'b1;
        step();
        chk("fl_req_req", {31'h0, bus_req}, 32'h1);
        flush = 1'b1; addr_valid = 1'b0;
        step();
        flush = 1'b0;
        chk("fl_req_drop", {31'h0, bus_req}, 32'h0);
        chk_quiet("fl_req");
        step();
        chk("fl_req_idle", {31'h0, bus_req}, 32'h0);
        chk_quiet("fl_req2");

        // Flush in WAIT, rvalid two cycles later
        addr = 32'h0000_0304; size = 2'd2; addr_valid = 1'b1;
        step();
        bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0; flush = 1'b1; addr_valid = 1'b0;
        step();
        flush = 1'b0;
        chk_quiet("fl_wait_c3");
        step();
        bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        chk_quiet("fl_wait_c4");
        step();
        bus_rvalid = 1'b0;
        chk_quiet("fl_wait_c5");
        step();
        chk_quiet("fl_wait_c6");
        do_load(32'h0000_0308, 2'd0, 0, 1, KindRvalid, 32'h0000_AB00);

        // Flush together with gnt in REQ goes to DRAIN
        addr = 32'h0000_0310; size = 2'd2; addr_valid = 1'b1;
        step();
        bus_gnt = 1'b1; flush = 1'b1; addr_valid = 1'b0;
        step();
        bus_gnt = 1'b0; flush = 1'b0; addr_valid = 1'b1;
        chk("fl_gnt_req", {31'h0, bus_req}, 32'h0);
        step();
        chk("fl_gnt_drain", {31'h0, bus_req}, 32'h0);
        bus_rvalid = 1'b1; addr_valid = 1'b0;
        step();
        bus_rvalid = 1'b0;
        chk_quiet("fl_gnt_done");
        step();
        chk("fl_gnt_idle", {31'h0, bus_req}, 32'h0);

        // Flush together with rvalid in WAIT: back to IDLE, return dropped
        addr = 32'h0000_0314; size = 2'd2; addr_valid = 1'b1;
        step();
        bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0; flush = 1'b1; bus_rvalid = 1'b1; addr_valid = 1'b0;
        step();
        flush = 1'b0; bus_rvalid = 1'b0;
        chk_quiet("fl_rv");
        do_load(32'h0000_0316, 2'd1, 0, 0, KindRvalid, 32'hCAFE_1234);

        // Flush with a request in IDLE: not accepted
        addr = 32'h0000_0320; size = 2'd2; addr_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; addr_valid = 1'b0;
        chk("fl_idle_req", {31'h0, bus_req}, 32'h0);
        chk_quiet("fl_idle");

        // Asynchronous reset while in WAIT
        addr = 32'h0000_0330; size = 2'd2; addr_valid = 1'b1;
        step();
        bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0;
        chk("rstw_addr_before", bus_addr, 32'h0000_0330);
        #2 rst_n = 1'b0;
        #1;
        chk("rstw_addr", bus_addr, 32'h0);
        chk("rstw_req", {31'h0, bus_req}, 32'h0);
        chk_quiet("rstw");
        addr_valid = 1'b0;
        #2 rst_n = 1'b1;
        step();
        bus_rvalid = 1'b1; bus_rdata = 32'h5555_AAAA;
        step();
        bus_rvalid = 1'b0;
        chk_quiet("rstw_stray");
        chk("rstw_stray_req", {31'h0, bus_req}, 32'h0);
        step();
        chk_quiet("rstw_stray2");

        // Randomized loads
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) ra = $urandom;
            else ra = MEM_BASE + $urandom_range(0, int'(MEM_SIZE) - 1);
            rs = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            // Bias toward aligned addresses so most requests reach the bus.
            if ($urandom_range(0, 3) != 0) begin
                if (rs == 2'd2) ra[1:0] = 2'b00;
                if (rs == 2'd1) ra[0] = 1'b0;
            end
            kind = ($urandom_range(0, 7) == 0) ? KindErr : KindRvalid;
            do_load(ra, rs, $urandom_range(0, 4), $urandom_range(0, 5), kind, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_port.md
# data_mem_port

Data-side memory port between `execute_load` and the data bus. Accepts one load request at a time on the `mem_data_*` handshake and checks size, alignment and address range. Issues a word-aligned read on a req/gnt/rvalid bus and returns the addressed byte, halfword or word right-aligned and zero-extended; sign extension stays in `execute_load`. Reports misalignment, out-of-range, bus error and timeout as `mem_data_access_fault`.

## Interface
- MEM_BASE, 32'h0000_0000, first valid data address
- MEM_SIZE, 32'h0001_0000, valid range size in bytes; valid iff `MEM_BASE <= addr` and `addr - MEM_BASE < MEM_SIZE` (32-bit unsigned)
- TIMEOUT, 16, max cycles in WAIT before fault; ≥1
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- flush  in  1  abandon current request; no response is produced
- mem_data_addr  in  32  byte address from execute_load
- mem_data_addr_valid  in  1  request valid; held with addr and size stable until response
- mem_data_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- mem_data_in  out  32  extracted read data, zero-extended
- mem_data_valid  out  1  one-cycle pulse, data good
- mem_data_access_fault  out  1  one-cycle pulse, request failed
- bus_addr  out  32  word-aligned address `{addr[31:2],2'b00}`
- bus_req  out  1  read request, held until bus_gnt
- bus_gnt  in  1  request accepted this cycle
- bus_rdata  in  32  read word, valid with bus_rvalid
- bus_rvalid  in  1  read data return
- bus_err  in  1  error return, replaces rvalid

## Operation
- Reset: state IDLE, all outputs 0, counter 0.
- FSM states: IDLE, REQ, WAIT, RESP, DRAIN.
- IDLE, addr_valid=1, flush=0: latch addr/size and check legality.
  - Fault if size=3, half with addr[0]=1, word with addr[1:0]≠0, or out of range.
  - On fault: go to RESP with fault=1. Otherwise go to REQ with bus_req=1 and bus_addr set.
- REQ: hold bus_req. On bus_gnt, drop bus_req, clear counter, go to WAIT.
- WAIT:
  - bus_rvalid → extract, go to RESP with valid=1.
  - bus_err → RESP with fault=1.
  - Otherwise increment counter. When counter reaches TIMEOUT-1 with no return → RESP with fault=1 and mark drain-pending.
- Extraction uses bus_rdata:
  - byte: lane addr[1:0] → bits[7:0]
  - half: lane addr[1] → bits[15:0]
  - word: unchanged
  - upper bits 0
- RESP: drives the pulse for exactly one cycle.
  - Next state is DRAIN if drain-pending, else IDLE.
  - mem_data_in holds the extracted value during the pulse; it is 0 on a fault and 0 outside RESP.
- DRAIN: bus_req=0, no responses, new requests ignored. Leave for IDLE on bus_rvalid or bus_err.
- Flush:
  - IDLE/RESP: ignored. The RESP pulse still fires.
  - REQ before gnt: drop bus_req, go to IDLE.
  - REQ in the same cycle as gnt: go to DRAIN.
  - WAIT: go to DRAIN. If rvalid/err arrives in the same cycle, go to IDLE and discard it.
  - DRAIN: no effect.
  - Flush and addr_valid together in IDLE: request not accepted.
- Stray bus_rvalid/bus_err in IDLE, REQ or RESP: ignored.
- Back-to-back: new request accepted in IDLE, earliest the cycle after the RESP pulse.

## Timing
- Request sampled in IDLE at cycle 0.
  - Illegal request: fault pulse in cycle 1.
  - Legal request: bus_req=1 from cycle 1.
- bus_gnt at cycle g: bus_req low from g+1.
- bus_rvalid at cycle r (r>g): mem_data_valid high in cycle r+1. Minimum legal-load latency is 3 cycles (gnt at 1, rvalid at 2, valid at 3).
- Timeout: gnt at g with no return → fault in cycle g+TIMEOUT+1.
- All outputs registered; no combinational path from bus inputs to mem_data_* outputs.
- Reset asserted mid-transaction: immediate return to IDLE with outputs 0. The bus is assumed reset by the same signal.

## Test plan
- Word load at 0x100, gnt in cycle 1, rvalid in cycle 2 with 0xDEADBEEF → bus_addr=0x100, valid pulse in cycle 3, mem_data_in=0xDEADBEEF.
- Byte load at 0x103 and half load at 0x102, both with rdata 0x8877_6655 → 0x0000_0088 and 0x0000_8877.
- Half at 0x101, word at 0x102, size=3, and addr MEM_BASE+MEM_SIZE → fault pulse in cycle 1; bus_req never asserted; mem_data_in=0.
- gnt delayed 4 cycles then bus_err → bus_req high for cycles 1–4, fault pulse the cycle after err. Separately, no return with TIMEOUT=16 → fault at g+17, DRAIN until a late rvalid, and a request issued during DRAIN is not accepted.
- Flush in cycle 1 (REQ, no gnt) → IDLE, no pulse. Flush in WAIT, rvalid two cycles later → no pulse, then IDLE, and the next request completes normally.
- reset pulled low while in WAIT → all outputs 0 asynchronously, state IDLE; rvalid arriving after reset release is ignored.
